taxi_eth_mac_stat_bank: RTL and testbench
=========================================

Name: taxi_eth_mac_stat_bank

Overview:
- Multi-channel statistics counter bank for the 10G MAC.
- Accumulates per-packet status strobes and the RX byte count from CH_CNT MAC channels into CNT_W-bit counters.
- Host reads counters through a valid/ready request/response port, with optional clear-on-read.
- Sits in the stat clock domain beside the MAC instances; the strobes arrive already synchronised to stat_clk.

Parameters:
- CH_CNT, 4: number of MAC channels (1..16).
- CNT_W, 32: counter width in bits (8..64).
- CH_W, (CH_CNT>1 ? $clog2(CH_CNT) : 1): width of the channel select field.

Ports:
- stat_clk  in  1  sole clock.
- stat_rst_n  in  1  reset, asynchronous assert, active-low.
- cnt_en  in  1  global count enable; 0 freezes all counters (reads and clears still work).
- clr_all  in  1  single-cycle pulse; clears every counter.
- stat_evt  in  CH_CNT*8  per-channel event strobes, channel c at bits [c*8+7:c*8]:
  - b0 rx_pkt_good, b1 rx_pkt_bad, b2 rx_err_bad_fcs, b3 rx_err_preamble
  - b4 rx_err_framing, b5 rx_err_oversize, b6 rx_pkt_fragment, b7 tx_pkt_good
- stat_rx_byte  in  CH_CNT*4  per-channel RX bytes this cycle (0..8); channel c at [c*4+3:c*4].
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when rd_valid && rd_ready.
- rd_ch  in  CH_W  channel select.
- rd_idx  in  4  counter index: 0..7 = event bits b0..b7, 8 = RX byte counter.
- rd_clr  in  1  clear the addressed counter on accept.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  CNT_W  counter value.
- rsp_err  out  1  address out of range (rd_ch >= CH_CNT or rd_idx > 8).

Behaviour:
- Reset (stat_rst_n=0, asynchronous):
  - All CH_CNT*9 counters = 0; FSM = IDLE.
  - Outputs: rd_ready=0 while in reset, rd_ready=1 from the first clock after release; rsp_valid=0, rsp_data=0, rsp_err=0.
- Counting, every stat_clk edge per counter:
  - Event counter: next = base + (cnt_en & evt_bit).
  - Byte counter: next = base + (cnt_en ? stat_rx_byte : 0). Byte values above 8 are added as given.
  - base = 0 if the counter is cleared this cycle (clr_all, or an accepted rd_clr addressing it); otherwise base = current value.
  - Consequence: an increment in the same cycle as a clear is never lost.
- Width rule:
  - Sums are computed at CNT_W+4 bits, then reduced per the optional feature.
  - Default is wrap modulo 2^CNT_W.
- FSM with two states:
  - IDLE: rd_ready=1, rsp_valid=0. On rd_valid, capture rsp_data = current (pre-increment) value of the addressed counter, set rsp_err, apply rd_clr, go to RESP.
  - RESP: rd_ready=0, rsp_valid=1; rsp_data and rsp_err held stable. On rsp_ready, go to IDLE.
- Latency: rsp_valid asserts exactly 1 cycle after accept.
- Throughput: 1 read per 2 cycles when rsp_ready is held at 1.
- Out-of-range read:
  - rsp_err=1, rsp_data=0.
  - rd_clr is ignored; no counter is modified.
- clr_all during RESP: counters clear; the held rsp_data is unaffected.
- cnt_en=0: counters hold, but clears still apply.

Optional Feature:
- Macro: TAXI_STAT_SAT_EN.
- Defined: counters saturate at 2^CNT_W-1 and stay there until cleared.
- Undefined: counters wrap modulo 2^CNT_W.
- The macro changes no ports.

Test Plan:
- Reset, then pulse ch2 b0 five times with cnt_en=1; read ch2 idx0 -> rsp_valid 1 cycle after accept, rsp_data=5, rsp_err=0.
- Drive ch1 stat_rx_byte=8 for 3 cycles, then 4 for 1 cycle; read ch1 idx8 with rd_clr=1 -> rsp_data=28. Re-read -> 0.
- Hold ch0 b7=1 continuously; issue rd_clr read of ch0 idx7 after 10 cycles -> rsp_data=10. Next read (2 cycles later, rsp_ready=1) -> 2, proving the same-cycle increment is kept.
- CNT_W=8, 260 pulses on ch3 b1 -> read returns 4 without TAXI_STAT_SAT_EN and 255 with it.
- Read ch0 idx9 and rd_ch=5 (CH_CNT=4), both with rd_clr=1 -> rsp_err=1, rsp_data=0, no counter changed.
- Hold rsp_ready=0 for 6 cycles while pulsing clr_all -> rsp_data stable, rd_ready=0 throughout; after rsp_ready, all counters read 0; assert stat_rst_n low mid-RESP -> rsp_valid drops immediately.

Source files
------------

// File: rtl/taxi_eth_mac_stat_bank.sv
// ============================================================================
// Module   : taxi_eth_mac_stat_bank
// Brief    : Per-channel MAC statistics counter bank with a valid/ready read
//            port and optional clear-on-read. Define TAXI_STAT_SAT_EN for
//            saturating counters; otherwise counters wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module taxi_eth_mac_stat_bank #(
    parameter int CH_CNT = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (CH_CNT > 1) ? $clog2(CH_CNT) : 1
) (
    input  logic                  stat_clk,
    input  logic                  stat_rst_n,
    input  logic                  cnt_en,
    input  logic                  clr_all,
    input  logic [CH_CNT*8-1:0]   stat_evt,
    input  logic [CH_CNT*4-1:0]   stat_rx_byte,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic [3:0]            rd_idx,
    input  logic                  rd_clr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CNT_W-1:0]      rsp_data,
    output logic                  rsp_err
);

    localparam int              c_IDX_N  = 9;
    localparam logic [CH_W:0]   c_CH_LIM = (CH_W+1)'(CH_CNT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_rd_ready;
    logic                   r_rsp_valid;
    logic [CNT_W-1:0]       r_rsp_data;
    logic                   r_rsp_err;

    logic [CNT_W-1:0]       r_cnt     [CH_CNT][c_IDX_N];
    logic [CNT_W-1:0]       w_cnt_nxt [CH_CNT][c_IDX_N];
    logic [CNT_W-1:0]       w_rd_val;
    logic                   w_in_range;
    logic                   w_acc;
    logic                   w_clr_sel;

    // Adds a 0..15 increment to a cleared-or-current base value.
    function automatic logic [CNT_W-1:0] f_acc(input logic [CNT_W-1:0] base,
                                               input logic [3:0]       inc);
`ifdef TAXI_STAT_SAT_EN
        logic [CNT_W+3:0] sum;
        sum = {4'b0000, base} + {{CNT_W{1'b0}}, inc};
        f_acc = (sum[CNT_W+3:CNT_W] != 4'd0) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
        // Truncating the add at CNT_W bits is the modulo-2^CNT_W reduction.
        f_acc = base + CNT_W'(inc);
`endif
    endfunction

    assign w_in_range = ({1'b0, rd_ch} < c_CH_LIM) && (rd_idx <= 4'd8);
    assign w_acc      = rd_valid && r_rd_ready;
    assign w_clr_sel  = w_acc && rd_clr && w_in_range;

    always_comb begin
        w_rd_val = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            for (int i = 0; i < c_IDX_N; i++) begin
                if (rd_ch == CH_W'(c) && rd_idx == 4'(i)) begin
                    w_rd_val = r_cnt[c][i];
                end
            end
        end
    end

    // A clear only zeroes the base, so a same-cycle increment still lands.
    always_comb begin
        for (int c = 0; c < CH_CNT; c++) begin
            for (int i = 0; i < 8; i++) begin
                w_cnt_nxt[c][i] = f_acc(
                    (clr_all || (w_clr_sel && rd_ch == CH_W'(c) && rd_idx == 4'(i)))
                        ? '0 : r_cnt[c][i],
                    {3'b000, cnt_en & stat_evt[c*8+i]});
            end
            w_cnt_nxt[c][8] = f_acc(
                (clr_all || (w_clr_sel && rd_ch == CH_W'(c) && rd_idx == 4'd8))
                    ? '0 : r_cnt[c][8],
                cnt_en ? stat_rx_byte[c*4 +: 4] : 4'd0);
        end
    end

    always_ff @(posedge stat_clk or negedge stat_rst_n) begin
        if (!stat_rst_n) begin
            for (int c = 0; c < CH_CNT; c++) begin
                for (int i = 0; i < c_IDX_N; i++) begin
                    r_cnt[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CH_CNT; c++) begin
                for (int i = 0; i < c_IDX_N; i++) begin
                    r_cnt[c][i] <= w_cnt_nxt[c][i];
                end
            end
        end
    end

    always_ff @(posedge stat_clk or negedge stat_rst_n) begin
        if (!stat_rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_ready  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_state     <= ST_RESP;
                        r_rd_ready  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_in_range ? w_rd_val : '0;
                        r_rsp_err   <= !w_in_range;
                    end else begin
                        r_rd_ready  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rd_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_ready  = r_rd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_taxi_eth_mac_stat_bank.sv
// ============================================================================
// Module   : tb_taxi_eth_mac_stat_bank
// Brief    : Directed self-checking bench for taxi_eth_mac_stat_bank
//            (4 channels, 8-bit counters, 3-bit channel field).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_taxi_eth_mac_stat_bank;

    localparam int CH_CNT = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;
`ifdef TAXI_STAT_SAT_EN
    localparam logic [63:0] c_EXP_260 = 64'd255;
`else
    localparam logic [63:0] c_EXP_260 = 64'd4;
`endif

    logic                  stat_clk = 1'b0;
    logic                  stat_rst_n = 1'b0;
    logic                  cnt_en = 1'b0;
    logic                  clr_all = 1'b0;
    logic [CH_CNT*8-1:0]   stat_evt = '0;
    logic [CH_CNT*4-1:0]   stat_rx_byte = '0;
    logic                  rd_valid = 1'b0;
    logic                  rd_ready;
    logic [CH_W-1:0]       rd_ch = '0;
    logic [3:0]            rd_idx = '0;
    logic                  rd_clr = 1'b0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [CNT_W-1:0]      rsp_data;
    logic                  rsp_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    taxi_eth_mac_stat_bank #(
        .CH_CNT (CH_CNT),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .stat_clk     (stat_clk),
        .stat_rst_n   (stat_rst_n),
        .cnt_en       (cnt_en),
        .clr_all      (clr_all),
        .stat_evt     (stat_evt),
        .stat_rx_byte (stat_rx_byte),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_ch        (rd_ch),
        .rd_idx       (rd_idx),
        .rd_clr       (rd_clr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    always #5 stat_clk = ~stat_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge stat_clk);
        #1;
    endtask

    task automatic start_read(input string tag, input int ch, input int idx, input logic clr);
        chk({tag, "_rdy"}, 64'(rd_ready), 64'd1);
        rd_valid = 1'b1;
        rd_ch    = CH_W'(ch);
        rd_idx   = 4'(idx);
        rd_clr   = clr;
        tick();
        rd_valid = 1'b0;
        rd_clr   = 1'b0;
    endtask

    task automatic finish_read(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_done"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic read_chk(input string tag, input int ch, input int idx, input logic clr,
                            input logic [63:0] exp_data, input logic exp_err);
        start_read(tag, ch, idx, clr);
        chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_data"}, 64'(rsp_data), exp_data);
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        finish_read(tag);
    endtask

    initial begin
        // Reset values, sampled between clock edges while reset is held.
        #23;
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        stat_rst_n = 1'b1;
        tick();
        chk("post_rst_rd_ready", 64'(rd_ready), 64'd1);
        cnt_en = 1'b1;

        // Five pulses on ch2 b0.
        repeat (5) begin
            stat_evt[16] = 1'b1;
            tick();
            stat_evt[16] = 1'b0;
            tick();
        end
        read_chk("t1_ch2_b0", 2, 0, 1'b0, 64'd5, 1'b0);

        // RX bytes on ch1: 8+8+8+4, then clear-on-read.
        stat_rx_byte[7:4] = 4'd8;
        repeat (3) tick();
        stat_rx_byte[7:4] = 4'd4;
        tick();
        stat_rx_byte[7:4] = 4'd0;
        read_chk("t2_ch1_byte", 1, 8, 1'b1, 64'd28, 1'b0);
        read_chk("t2_ch1_byte_reread", 1, 8, 1'b0, 64'd0, 1'b0);

        // Continuous ch0 b7: clear-on-read keeps the same-cycle increment.
        stat_evt[7] = 1'b1;
        repeat (10) tick();
        read_chk("t3_ch0_b7_clr", 0, 7, 1'b1, 64'd10, 1'b0);
        read_chk("t3_ch0_b7_next", 0, 7, 1'b0, 64'd2, 1'b0);
        stat_evt[7] = 1'b0;

        // 260 events on ch3 b1 exceed the 8-bit range.
        stat_evt[25] = 1'b1;
        repeat (260) tick();
        stat_evt[25] = 1'b0;
        read_chk("t4_ch3_b1_ovf", 3, 1, 1'b0, c_EXP_260, 1'b0);

        // cnt_en=0 freezes counting.
        cnt_en = 1'b0;
        stat_evt[16] = 1'b1;
        stat_rx_byte[11:8] = 4'd7;
        repeat (3) tick();
        stat_evt[16] = 1'b0;
        stat_rx_byte[11:8] = 4'd0;
        cnt_en = 1'b1;
        read_chk("t4_cnt_en_off_evt", 2, 0, 1'b0, 64'd5, 1'b0);
        read_chk("t4_cnt_en_off_byte", 2, 8, 1'b0, 64'd0, 1'b0);

        // Out-of-range reads with rd_clr must not touch any counter.
        repeat (3) begin
            stat_evt[8] = 1'b1;
            tick();
            stat_evt[8] = 1'b0;
            tick();
        end
        read_chk("t5_idx9", 0, 9, 1'b1, 64'd0, 1'b1);
        read_chk("t5_ch5", 5, 0, 1'b1, 64'd0, 1'b1);
        read_chk("t5_ch1_b0", 1, 0, 1'b0, 64'd3, 1'b0);
        read_chk("t5_ch0_b7", 0, 7, 1'b0, 64'd4, 1'b0);
        read_chk("t5_ch3_b1", 3, 1, 1'b0, c_EXP_260, 1'b0);

        // Stalled response with clr_all underneath.
        start_read("t6_hold", 2, 0, 1'b0);
        chk("t6_hold_vld", 64'(rsp_valid), 64'd1);
        chk("t6_hold_data0", 64'(rsp_data), 64'd5);
        clr_all = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            clr_all = 1'b0;
            chk("t6_hold_data", 64'(rsp_data), 64'd5);
            chk("t6_hold_rdy", 64'(rd_ready), 64'd0);
            chk("t6_hold_vld", 64'(rsp_valid), 64'd1);
        end
        finish_read("t6_hold");
        for (int c = 0; c < CH_CNT; c++) begin
            for (int i = 0; i < 9; i++) begin
                read_chk("t6_all_zero", c, i, 1'b0, 64'd0, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a response.
        start_read("t6_rst", 3, 1, 1'b0);
        chk("t6_rst_vld_before", 64'(rsp_valid), 64'd1);
        #2;
        stat_rst_n = 1'b0;
        #1;
        chk("t6_rst_vld_async", 64'(rsp_valid), 64'd0);
        chk("t6_rst_rdy_async", 64'(rd_ready), 64'd0);
        #2;
        stat_rst_n = 1'b1;
        tick();
        chk("t6_rst_rdy_after", 64'(rd_ready), 64'd1);
        chk("t6_rst_vld_after", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
